// File: rtl/mem_stage_hs.sv
// Purpose : MEM pipeline stage. Aligns stores onto byte lanes (with store-data
//           forwarding), runs a req/ack bus handshake with timeout, extracts and
//           sign/zero-extends load data, and registers the WB-stage outputs.
// Latency : non-memory and misaligned ops: 1 edge. Memory ops: 1 edge to issue,
//           then complete on the edge after bus_ack (or after TIMEOUT cycles).
// Backpr. : busy holds upstream while a memory op is outstanding; stall_in freezes
//           the output registers (a finished bus result parks in HOLD); clr flushes.
// Ports   : clk/reset (sync, active-high); stall_in, clr; instruction inputs
//           (valid_in, pc_in, mem_op, addr, wdata, rt_addr, wb_*_in, tnew_in);
//           forwarding buses fwd_addr/fwd_data (index 0 = highest priority);
//           bus_req/we/addr/be/wdata out, bus_ack/rdata in; busy; registered
//           WB outputs valid_out, pc_out, wb_addr_out, wb_data_out, tnew_out, exc_out.
module mem_stage_hs #(
    parameter int NUM_FWD = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall_in,
    input  logic                   clr,
    input  logic                   valid_in,
    input  logic [31:0]            pc_in,
    input  logic [4:0]             mem_op,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    input  logic [4:0]             rt_addr,
    input  logic [4:0]             wb_addr_in,
    input  logic [31:0]            wb_data_in,
    input  logic [1:0]             tnew_in,
    input  logic [NUM_FWD*5-1:0]   fwd_addr,
    input  logic [NUM_FWD*32-1:0]  fwd_data,
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [31:0]            bus_addr,
    output logic [3:0]             bus_be,
    output logic [31:0]            bus_wdata,
    input  logic                   bus_ack,
    input  logic [31:0]            bus_rdata,
    output logic                   busy,
    output logic                   valid_out,
    output logic [31:0]            pc_out,
    output logic [4:0]             wb_addr_out,
    output logic [31:0]            wb_data_out,
    output logic [1:0]             tnew_out,
    output logic [4:0]             exc_out
);

    localparam int           CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_V  = CW'(TIMEOUT);
    localparam logic [4:0]   EXC_LD  = 5'd4;
    localparam logic [4:0]   EXC_ST  = 5'd5;
    localparam logic [4:0]   EXC_TMO = 5'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          kill_q;       // transaction was flushed; its completion loads a bubble

    // Captured transaction context
    logic [29:0]   baddr_q;
    logic [1:0]    off_q;
    logic [3:0]    be_q;
    logic [31:0]   wd_q;
    logic          we_q;
    logic          ld_q;
    logic          uns_q;
    logic [1:0]    size_q;
    logic [31:0]   pc_q;
    logic [4:0]    wba_q;
    logic [1:0]    tnew_q;
    logic [31:0]   rdat_q;       // read word parked while stalled in HOLD
    logic          tmo_q;        // HOLD entered because of a timeout

    // Decode
    logic is_ld, is_st, is_mem, mis;
    assign is_ld  = mem_op[4];
    assign is_st  = mem_op[3] & ~mem_op[4];
    assign is_mem = is_ld | is_st;
    assign mis    = ((mem_op[1:0] == 2'd1) & addr[0]) |
                    (mem_op[1] & (addr[1:0] != 2'b00));

    function automatic logic [1:0] tdec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Store data: scan from the lowest-priority source upward so index 0 wins.
    // Register 0 is never forwarded.
    logic [31:0] st_src;
    always_comb begin
        st_src = wdata;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if ((fwd_addr[i*5 +: 5] == rt_addr) && (fwd_addr[i*5 +: 5] != 5'd0))
                st_src = fwd_data[i*32 +: 32];
        end
    end

    // Lane placement and byte enables
    logic [31:0] lane_nx;
    logic [3:0]  be_nx;
    always_comb begin
        lane_nx = st_src;
        be_nx   = 4'b1111;
        case (mem_op[1:0])
            2'd0: begin
                lane_nx = {4{st_src[7:0]}};
                be_nx   = 4'b0001 << addr[1:0];
            end
            2'd1: begin
                lane_nx = {2{st_src[15:0]}};
                be_nx   = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_nx = st_src;
                be_nx   = 4'b1111;
            end
        endcase
    end

    // FSM next state and handshake
    logic start, tmo, ack_eff, fin, busy_c, req_c;
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        tmo      = 1'b0;
        ack_eff  = 1'b0;
        fin      = 1'b0;
        busy_c   = 1'b0;
        req_c    = 1'b0;
        case (state)
            IDLE: begin
                // A flushed instruction never reaches the bus.
                if (valid_in && is_mem && !mis && !clr) begin
                    busy_c   = 1'b1;
                    start    = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                tmo     = (cnt == TMO_V);
                req_c   = ~tmo;
                ack_eff = bus_ack & ~tmo;   // a late ack after the drop is ignored
                busy_c  = ~(ack_eff | tmo);
                fin     = (ack_eff | tmo) & ~stall_in;
                if (ack_eff || tmo)
                    state_nx = stall_in ? HOLD : IDLE;
            end
            HOLD: begin
                if (!stall_in) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = busy_c & ~reset;
    assign bus_req   = req_c & ~reset;
    assign bus_we    = bus_req & we_q;
    assign bus_addr  = {baddr_q, 2'b00};
    assign bus_be    = be_q;
    assign bus_wdata = wd_q;

    // Load extraction
    logic [31:0] ld_word, shifted, ld_val;
    always_comb begin
        ld_word = (state == HOLD) ? rdat_q : bus_rdata;
        shifted = ld_word >> {off_q, 3'b000};
        case (size_q)
            2'd0:    ld_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'd1:    ld_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: ld_val = ld_word;
        endcase
    end

    // Next output record; all-zero is the bubble
    logic        o_vld;
    logic [31:0] o_pc;
    logic [4:0]  o_wba;
    logic [31:0] o_wbd;
    logic [1:0]  o_tnew;
    logic [4:0]  o_exc;
    logic        tmo_eff;
    always_comb begin
        o_vld   = 1'b0;
        o_pc    = 32'd0;
        o_wba   = 5'd0;
        o_wbd   = 32'd0;
        o_tnew  = 2'd0;
        o_exc   = 5'd0;
        tmo_eff = (state == HOLD) ? tmo_q : tmo;
        if (state == IDLE) begin
            if (valid_in && (!is_mem || mis)) begin
                o_vld  = 1'b1;
                o_pc   = pc_in;
                o_wba  = is_mem ? 5'd0 : wb_addr_in;
                o_wbd  = wb_data_in;
                o_tnew = tdec(tnew_in);
                o_exc  = !is_mem ? 5'd0 : (is_ld ? EXC_LD : EXC_ST);
            end
        end else if (fin && !kill_q) begin
            o_vld  = 1'b1;
            o_pc   = pc_q;
            o_tnew = tdec(tnew_q);
            if (tmo_eff) begin
                o_exc = EXC_TMO;
            end else if (ld_q) begin
                o_wba = wba_q;
                o_wbd = ld_val;
            end
        end
    end

    // FSM and transaction context
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            kill_q  <= 1'b0;
            baddr_q <= 30'd0;
            off_q   <= 2'd0;
            be_q    <= 4'd0;
            wd_q    <= 32'd0;
            we_q    <= 1'b0;
            ld_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            pc_q    <= 32'd0;
            wba_q   <= 5'd0;
            tnew_q  <= 2'd0;
            rdat_q  <= 32'd0;
            tmo_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                cnt     <= '0;
                kill_q  <= 1'b0;
                baddr_q <= addr[31:2];
                off_q   <= addr[1:0];
                be_q    <= be_nx;
                wd_q    <= lane_nx;
                we_q    <= is_st;
                ld_q    <= is_ld;
                uns_q   <= mem_op[2];
                size_q  <= mem_op[1:0];
                pc_q    <= pc_in;
                wba_q   <= wb_addr_in;
                tnew_q  <= tnew_in;
            end else if (state == REQ && !(ack_eff || tmo)) begin
                cnt <= cnt + CW'(1);
            end
            if (state != IDLE && clr)
                kill_q <= 1'b1;
            if (state == REQ && (ack_eff || tmo)) begin
                rdat_q <= bus_rdata;
                tmo_q  <= tmo;
            end
        end
    end

    // WB-stage output registers: clr beats stall_in
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            valid_out   <= 1'b0;
            pc_out      <= 32'd0;
            wb_addr_out <= 5'd0;
            wb_data_out <= 32'd0;
            tnew_out    <= 2'd0;
            exc_out     <= 5'd0;
        end else if (!stall_in) begin
            valid_out   <= o_vld;
            pc_out      <= o_pc;
            wb_addr_out <= o_wba;
            wb_data_out <= o_wbd;
            tnew_out    <= o_tnew;
            exc_out     <= o_exc;
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Purpose : self-checking bench for mem_stage_hs; table of single-cycle vectors
//           plus hand-written sequences for bus handshakes, HOLD, flush, timeout.
// Ports   : drives every DUT input, checks outputs #1 after the rising edge.
module tb_mem_stage_hs;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        clr;
    logic        valid_in;
    logic [31:0] pc_in;
    logic [4:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rt_addr;
    logic [4:0]  wb_addr_in;
    logic [31:0] wb_data_in;
    logic [1:0]  tnew_in;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        busy;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [4:0]  wb_addr_out;
    logic [31:0] wb_data_out;
    logic [1:0]  tnew_out;
    logic [4:0]  exc_out;

    int errors;
    int checks;

    mem_stage_hs #(.NUM_FWD(2), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .clr(clr),
        .valid_in(valid_in), .pc_in(pc_in), .mem_op(mem_op), .addr(addr),
        .wdata(wdata), .rt_addr(rt_addr), .wb_addr_in(wb_addr_in),
        .wb_data_in(wb_data_in), .tnew_in(tnew_in), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .busy(busy),
        .valid_out(valid_out), .pc_out(pc_out), .wb_addr_out(wb_addr_out),
        .wb_data_out(wb_data_out), .tnew_out(tnew_out), .exc_out(exc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        stall;
        logic        cl;
        logic        vld;
        logic [31:0] pc;
        logic [4:0]  op;
        logic [31:0] ad;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic [1:0]  tn;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [4:0]  e_wba;
        logic [31:0] e_wbd;
        logic [1:0]  e_tn;
        logic [4:0]  e_exc;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_vld, input logic [31:0] e_pc,
                           input logic [4:0] e_wba, input logic [31:0] e_wbd,
                           input logic [1:0] e_tn, input logic [4:0] e_exc);
        chk({tag, ".valid_out"},   32'(valid_out),   32'(e_vld));
        chk({tag, ".pc_out"},      pc_out,           e_pc);
        chk({tag, ".wb_addr_out"}, 32'(wb_addr_out), 32'(e_wba));
        chk({tag, ".wb_data_out"}, wb_data_out,      e_wbd);
        chk({tag, ".tnew_out"},    32'(tnew_out),    32'(e_tn));
        chk({tag, ".exc_out"},     32'(exc_out),     32'(e_exc));
    endtask

    task automatic drive(input logic st, input logic cl, input logic vl, input logic [31:0] pc,
                         input logic [4:0] op, input logic [31:0] ad, input logic [4:0] wba,
                         input logic [31:0] wbd, input logic [1:0] tn);
        stall_in   = st;
        clr        = cl;
        valid_in   = vl;
        pc_in      = pc;
        mem_op     = op;
        addr       = ad;
        wb_addr_in = wba;
        wb_data_in = wbd;
        tnew_in    = tn;
    endtask

    // Called right after inputs for a memory op are applied in IDLE.
    // Acks after wait_n extra REQ cycles; returns #1 after the completion edge.
    task automatic do_mem(input string tag, input int wait_n, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic [3:0] e_be, input logic e_we,
                          input logic [31:0] e_wd, input int e_busy);
        int nb;
        nb = 0;
        #1;
        if (busy === 1'b1) nb++;
        @(posedge clk); #1;
        chk({tag, ".bus_req"},  32'(bus_req), 32'd1);
        chk({tag, ".bus_addr"}, bus_addr,     e_addr);
        chk({tag, ".bus_be"},   32'(bus_be),  32'(e_be));
        chk({tag, ".bus_we"},   32'(bus_we),  32'(e_we));
        if (e_we) chk({tag, ".bus_wdata"}, bus_wdata, e_wd);
        for (int k = 0; k < wait_n; k++) begin
            if (busy === 1'b1) nb++;
            @(posedge clk); #1;
        end
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        #1;
        if (busy === 1'b1) nb++;
        @(posedge clk); #1;
        bus_ack  = 1'b0;
        valid_in = 1'b0;
        chk({tag, ".busy_cycles"}, 32'(nb), 32'(e_busy));
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;
        bus_ack = 1'b0;
        bus_rdata = 32'd0;
        wdata = 32'd0;
        rt_addr = 5'd0;
        fwd_addr = 10'd0;
        fwd_data = 64'd0;

        // Reset with an aligned load presented: nothing may start
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 32'h40, 5'h12, 32'h40, 5'd1, 32'h0, 2'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.bus_req", 32'(bus_req), 32'd0);
        chk_out("rst", 1'b0, 32'h0, 5'd0, 32'h0, 2'd0, 5'd0);
        reset = 1'b0;
        valid_in = 1'b0;

        //           stall clr  vld  pc      op     addr     wba   wbd           tn  | vld  pc      wba   wbd           tn    exc
        vt[0]  = '{1'b0, 1'b0, 1'b1, 32'h100, 5'h00, 32'h000, 5'd3, 32'h11112222, 2'd2, 1'b1, 32'h100, 5'd3, 32'h11112222, 2'd1, 5'd0};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 32'h104, 5'h00, 32'h000, 5'd7, 32'h00000055, 2'd0, 1'b1, 32'h104, 5'd7, 32'h00000055, 2'd0, 5'd0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 32'h108, 5'h00, 32'h000, 5'd9, 32'h00000066, 2'd3, 1'b1, 32'h104, 5'd7, 32'h00000055, 2'd0, 5'd0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 32'h10C, 5'h00, 32'h000, 5'd9, 32'h00000066, 2'd3, 1'b1, 32'h10C, 5'd9, 32'h00000066, 2'd2, 5'd0};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 32'h110, 5'h00, 32'h000, 5'd1, 32'h00000001, 2'd1, 1'b0, 32'h000, 5'd0, 32'h00000000, 2'd0, 5'd0};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 32'h114, 5'h12, 32'h006, 5'd9, 32'h00000077, 2'd3, 1'b1, 32'h114, 5'd0, 32'h00000077, 2'd2, 5'd4};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 32'h118, 5'h09, 32'h101, 5'd4, 32'h00000088, 2'd1, 1'b1, 32'h118, 5'd0, 32'h00000088, 2'd0, 5'd5};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 32'h11C, 5'h00, 32'h000, 5'd5, 32'h00000099, 2'd2, 1'b0, 32'h000, 5'd0, 32'h00000000, 2'd0, 5'd0};
        vt[8]  = '{1'b0, 1'b0, 1'b1, 32'h120, 5'h15, 32'h003, 5'd2, 32'h00000099, 2'd0, 1'b1, 32'h120, 5'd0, 32'h00000099, 2'd0, 5'd4};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 32'h124, 5'h0A, 32'h10A, 5'd6, 32'h000000AA, 2'd1, 1'b1, 32'h124, 5'd0, 32'h000000AA, 2'd0, 5'd5};
        vt[10] = '{1'b0, 1'b1, 1'b1, 32'h128, 5'h00, 32'h000, 5'd3, 32'h000000BB, 2'd2, 1'b0, 32'h000, 5'd0, 32'h00000000, 2'd0, 5'd0};

        for (int i = 0; i < 11; i++) begin
            drive(vt[i].stall, vt[i].cl, vt[i].vld, vt[i].pc, vt[i].op, vt[i].ad,
                  vt[i].wba, vt[i].wbd, vt[i].tn);
            #1;
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'd0);
            chk($sformatf("vec%0d.bus_req", i), 32'(bus_req), 32'd0);
            @(posedge clk); #1;
            chk_out($sformatf("vec%0d", i), vt[i].e_vld, vt[i].e_pc, vt[i].e_wba,
                    vt[i].e_wbd, vt[i].e_tn, vt[i].e_exc);
        end

        // Word load, ack after 3 waiting cycles
        drive(1'b0, 1'b0, 1'b1, 32'h200, 5'h12, 32'h104, 5'd8, 32'h0, 2'd2);
        do_mem("ldw", 3, 32'hDEADBEEF, 32'h104, 4'b1111, 1'b0, 32'h0, 4);
        chk_out("ldw", 1'b1, 32'h200, 5'd8, 32'hDEADBEEF, 2'd1, 5'd0);

        // Load lane extraction
        drive(1'b0, 1'b0, 1'b1, 32'h204, 5'h10, 32'h103, 5'd9, 32'h0, 2'd1);
        do_mem("lbs", 0, 32'h80123456, 32'h100, 4'b1000, 1'b0, 32'h0, 1);
        chk_out("lbs", 1'b1, 32'h204, 5'd9, 32'hFFFFFF80, 2'd0, 5'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h208, 5'h14, 32'h103, 5'd9, 32'h0, 2'd1);
        do_mem("lbu", 0, 32'h80123456, 32'h100, 4'b1000, 1'b0, 32'h0, 1);
        chk_out("lbu", 1'b1, 32'h208, 5'd9, 32'h00000080, 2'd0, 5'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h20C, 5'h11, 32'h102, 5'd3, 32'h0, 2'd3);
        do_mem("lhs", 1, 32'h80017FFF, 32'h100, 4'b1100, 1'b0, 32'h0, 2);
        chk_out("lhs", 1'b1, 32'h20C, 5'd3, 32'hFFFF8001, 2'd2, 5'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h210, 5'h14, 32'h101, 5'd4, 32'h0, 2'd0);
        do_mem("lbu1", 0, 32'h0000AB00, 32'h100, 4'b0010, 1'b0, 32'h0, 1);
        chk_out("lbu1", 1'b1, 32'h210, 5'd4, 32'h000000AB, 2'd0, 5'd0);

        // Stores with forwarding priority
        wdata = 32'hFFFF0000; rt_addr = 5'd5;
        fwd_addr = {5'd5, 5'd5}; fwd_data = {32'h00001234, 32'h0000ABCD};
        drive(1'b0, 1'b0, 1'b1, 32'h220, 5'h09, 32'h002, 5'd12, 32'h0, 2'd2);
        do_mem("sh", 0, 32'h0, 32'h000, 4'b1100, 1'b1, 32'hABCDABCD, 1);
        chk_out("sh", 1'b1, 32'h220, 5'd0, 32'h0, 2'd1, 5'd0);
        wdata = 32'h00000011; rt_addr = 5'd6;
        fwd_addr = {5'd6, 5'd3}; fwd_data = {32'h0000005A, 32'h000000FF};
        drive(1'b0, 1'b0, 1'b1, 32'h224, 5'h08, 32'h101, 5'd6, 32'h0, 2'd1);
        do_mem("sb", 2, 32'h0, 32'h100, 4'b0010, 1'b1, 32'h5A5A5A5A, 3);
        chk_out("sb", 1'b1, 32'h224, 5'd0, 32'h0, 2'd0, 5'd0);
        wdata = 32'h01020304; rt_addr = 5'd0;
        fwd_addr = 10'd0; fwd_data = {32'hEEEEEEEE, 32'hDDDDDDDD};
        drive(1'b0, 1'b0, 1'b1, 32'h228, 5'h0A, 32'h108, 5'd1, 32'h0, 2'd0);
        do_mem("sw", 0, 32'h0, 32'h108, 4'b1111, 1'b1, 32'h01020304, 1);
        chk_out("sw", 1'b1, 32'h228, 5'd0, 32'h0, 2'd0, 5'd0);

        // Ack under stall: result parked in HOLD, bus_rdata changes meanwhile
        drive(1'b0, 1'b0, 1'b1, 32'h240, 5'h12, 32'h030, 5'd10, 32'h0, 2'd0);
        #1;
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D; stall_in = 1'b1;
        #1;
        chk("hold.busy_at_ack", 32'(busy), 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = 32'h0BADBAD0; valid_in = 1'b0;
        chk("hold.bus_req", 32'(bus_req), 32'd0);
        chk("hold.busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        stall_in = 1'b0;
        @(posedge clk); #1;
        chk_out("hold", 1'b1, 32'h240, 5'd10, 32'hCAFEF00D, 2'd0, 5'd0);

        // Flush during REQ, ack under stall: completion must be a bubble
        drive(1'b0, 1'b0, 1'b1, 32'h300, 5'h12, 32'h020, 5'd4, 32'h0, 2'd2);
        #1;
        @(posedge clk); #1;
        clr = 1'b1;
        #1;
        chk("kill.bus_req_in_clr", 32'(bus_req), 32'd1);
        @(posedge clk); #1;
        chk("kill.valid_after_clr", 32'(valid_out), 32'd0);
        clr = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h12345678; stall_in = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b0; valid_in = 1'b0;
        chk("kill.hold_bus_req", 32'(bus_req), 32'd0);
        stall_in = 1'b0;
        @(posedge clk); #1;
        chk_out("kill", 1'b0, 32'h0, 5'd0, 32'h0, 2'd0, 5'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h304, 5'h00, 32'h0, 5'd2, 32'h42, 2'd1);
        #1;
        chk("kill.idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk_out("kill.next", 1'b1, 32'h304, 5'd2, 32'h42, 2'd0, 5'd0);

        // Timeout: no ack at all
        drive(1'b0, 1'b0, 1'b1, 32'h400, 5'h12, 32'h050, 5'd11, 32'h0, 2'd1);
        #1;
        @(posedge clk); #1;
        n = 0;
        while (bus_req === 1'b1 && n < 400) begin
            n++;
            @(posedge clk); #1;
        end
        chk("tmo.req_cycles", 32'(n), 32'd255);
        chk("tmo.busy", 32'(busy), 32'd0);
        valid_in = 1'b0;
        @(posedge clk); #1;
        chk_out("tmo", 1'b1, 32'h400, 5'd0, 32'h0, 2'd0, 5'd6);

        // Reset aborts an outstanding transaction
        drive(1'b0, 1'b0, 1'b1, 32'h500, 5'h12, 32'h060, 5'd3, 32'h0, 2'd1);
        #1;
        @(posedge clk); #1;
        chk("rsta.bus_req_before", 32'(bus_req), 32'd1);
        reset = 1'b1; valid_in = 1'b0;
        #1;
        chk("rsta.bus_req_in_reset", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rsta.bus_req_after", 32'(bus_req), 32'd0);
        chk("rsta.busy_after", 32'(busy), 32'd0);
        chk("rsta.valid_out", 32'(valid_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 Parameter NUM_FWD, default 2: forwarding sources; index 0 has highest priority.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles in REQ without bus_ack.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 stall_in  in  1  downstream stall; holds output registers.
REQ-006 clr  in  1  flush; output registers load a bubble.
REQ-007 valid_in  in  1  input instruction valid.
REQ-008 pc_in  in  32  instruction PC.
REQ-009 mem_op  in  5  [4]=load, [3]=store, [2]=unsigned, [1:0]=size (0 byte, 1 half, 2 word).
REQ-010 addr  in  32  effective address.
REQ-011 wdata / rt_addr  in  32 / 5  store data and its source register.
REQ-012 wb_addr_in / wb_data_in  in  5 / 32  writeback target and data for non-loads.
REQ-013 tnew_in  in  2  producer Tnew.
REQ-014 fwd_addr / fwd_data  in  NUM_FWD*5 / NUM_FWD*32  packed forwarding sources.
REQ-015 bus_req / bus_we  out  1 / 1  bus request and write strobe.
REQ-016 bus_addr / bus_be / bus_wdata  out  32 / 4 / 32  word-aligned address ([1:0]=0), byte enables, lane data.
REQ-017 bus_ack / bus_rdata  in  1 / 32  completion and read word.
REQ-018 busy  out  1  current input not consumed; upstream holds.
REQ-019 valid_out, pc_out, wb_addr_out, wb_data_out, tnew_out, exc_out  out  1, 32, 5, 32, 2, 5  registered WB-stage outputs.

Function
REQ-020 Store data SHALL come from the lowest-index source with fwd_addr[i]==rt_addr and fwd_addr[i]!=0; otherwise wdata.
REQ-021 Misalignment: half with addr[0]=1, or word with addr[1:0]!=0. Such an op SHALL issue no bus access and complete like a non-memory op with exc_out=4 (load) or 5 (store) and wb_addr_out=0.
REQ-022 Non-memory ops and misaligned ops SHALL load the outputs at the next edge when !stall_in; busy=0; tnew_out=max(tnew_in-1,0).
REQ-023 FSM IDLE/REQ/HOLD. In IDLE, a valid aligned memory op SHALL assert busy, capture address, BE, lane data and write flag, and go to REQ.
REQ-024 In REQ: bus_req=1 and bus signals stable until bus_ack; busy=!bus_ack. On bus_ack: if !stall_in, load outputs and go to IDLE; otherwise latch bus_rdata and go to HOLD.
REQ-025 In HOLD: bus_req=0; when !stall_in, load outputs and go to IDLE.
REQ-026 Store lanes: byte data replicated x4 with BE=1<<addr[1:0]; half data replicated x2 with BE=0011 or 1100; word BE=1111.
REQ-027 Load result SHALL select the lane at addr[1:0], then zero-extend (mem_op[2]=1) or sign-extend. Stores SHALL write wb_addr_out=0.
REQ-028 Timeout counter: reset on entering REQ. When it reaches TIMEOUT without bus_ack, drop bus_req, complete with exc_out=6 and wb_addr_out=0.
REQ-029 clr has priority over stall_in and zeroes all outputs. If clr arrives in REQ or HOLD, the bus transaction SHALL finish and its completion SHALL load a bubble.

Reset
REQ-030 On reset: state=IDLE, counter=0, kill flag=0, and all outputs including bus_req and busy are 0. Reset aborts any transaction immediately.

Verification
REQ-031 Word load, addr=0x104, bus_ack after 3 cycles, rdata=0xDEADBEEF -> busy high for 4 cycles; wb_data_out=0xDEADBEEF one edge after ack.
REQ-032 Signed byte load, addr=0x103, rdata=0x80xxxxxx -> wb_data_out=0xFFFFFF80. Same case unsigned -> 0x00000080.
REQ-033 Half store, addr=0x2, rt_addr=5, fwd_addr[1]=5 with data 0x1234 and fwd_addr[0]=5 with data 0xABCD -> bus_wdata=0xABCDABCD, bus_be=1100.
REQ-034 Word load at addr=0x6 -> bus_req never asserted; exc_out=4, wb_addr_out=0.
REQ-035 bus_ack never arrives, TIMEOUT=255 -> bus_req drops after 255 cycles; exc_out=6.
REQ-036 clr during REQ, then ack with stall_in=1 -> FSM passes through HOLD; completion loads all-zero outputs.
